// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_ctrl
//  Purpose  : MEM-stage controller: issues data-cache requests, waits for
//             dhit, builds the MEM/WB payload, and reports stall/halt/timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ex_mem_valid,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_mem_store_data,
    input  logic [4:0]  ex_mem_rd,
    input  logic        ex_mem_reg_wen,
    input  logic        ex_mem_halt,
    input  logic        stall_in,
    input  logic        dhit,
    input  logic [31:0] dmemload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_wen,
    output logic        wb_halt,
    output logic        mem_wb_en,
    output logic        mem_wb_flush,
    output logic        mem_stall,
    output logic        halted,
    output logic        mem_err
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;
    localparam logic [1:0] c_HALTED = 2'd3;

    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [31:0]      r_hold_data;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_halted;
    logic             r_mem_err;

    logic             w_memop;
    logic             w_req;
    logic             w_en;
    logic             w_flush;
    logic             w_stall;
    logic             w_retire_halt;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_memop = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);

    always_comb begin
        w_req   = 1'b0;
        w_en    = 1'b0;
        w_flush = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_req = w_memop;
                if (w_memop) begin
                    w_en    = dhit & ~stall_in;
                    w_stall = ~dhit;
                end else begin
                    w_en    = ~stall_in;
                    w_flush = ~ex_mem_valid;
                end
            end
            c_ACCESS: begin
                w_req   = 1'b1;
                w_en    = dhit & ~stall_in;
                w_stall = ~dhit;
            end
            c_HOLD: begin
                // Access already done; never re-issue (a store must not repeat).
                w_en = ~stall_in;
            end
            default: ;
        endcase
    end

    assign w_retire_halt = w_en & ex_mem_valid & ex_mem_halt;
    assign w_cnt_inc     = (r_wait_cnt == {CNT_W{1'b1}}) ? r_wait_cnt : r_wait_cnt + c_ONE;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= c_IDLE;
            r_hold_data <= 32'd0;
            r_wait_cnt  <= '0;
            r_halted    <= 1'b0;
            r_mem_err   <= 1'b0;
        end else if (w_retire_halt) begin
            r_state    <= c_HALTED;
            r_halted   <= 1'b1;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_memop && dhit && stall_in) begin
                        r_hold_data <= dmemload;
                        r_state     <= c_HOLD;
                    end else if (w_memop && !dhit) begin
                        r_state    <= c_ACCESS;
                        r_wait_cnt <= c_ONE;
                        if (c_ONE >= c_LIMIT) r_mem_err <= 1'b1;
                    end
                end
                c_ACCESS: begin
                    if (dhit) begin
                        r_wait_cnt <= '0;
                        if (stall_in) begin
                            r_hold_data <= dmemload;
                            r_state     <= c_HOLD;
                        end else begin
                            r_state <= c_IDLE;
                        end
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= c_LIMIT) r_mem_err <= 1'b1;
                    end
                end
                c_HOLD: begin
                    if (!stall_in) r_state <= c_IDLE;
                end
                default: r_state <= c_HALTED;
            endcase
        end
    end

    // Every output is forced low while nRST is asserted so requests drop at once.
    assign dmemREN      = nRST & w_req & ex_mem_mem_read;
    assign dmemWEN      = nRST & w_req & ex_mem_mem_write & ~ex_mem_mem_read;
    assign dmemaddr     = (nRST & w_req) ? ex_mem_addr       : 32'd0;
    assign dmemstore    = (nRST & w_req) ? ex_mem_store_data : 32'd0;
    assign mem_wb_en    = nRST & w_en;
    assign mem_wb_flush = nRST & w_flush;
    assign mem_stall    = nRST & w_stall;
    assign halted       = r_halted;
    assign mem_err      = r_mem_err;

    assign wb_data    = !nRST ? 32'd0 :
                        ex_mem_mem_read ? ((r_state == c_HOLD) ? r_hold_data : dmemload)
                                        : ex_mem_addr;
    assign wb_rd      = nRST ? ex_mem_rd : 5'd0;
    assign wb_reg_wen = nRST & ex_mem_reg_wen;
    assign wb_halt    = nRST & ex_mem_halt;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// Bench for mem_stage_ctrl: IDLE-state vector table plus multi-cycle sequences
// (miss, freeze/hold, timeout, halt, asynchronous reset).
module tb_mem_stage_ctrl;

    logic        CLK;
    logic        nRST;
    logic        ex_mem_valid, ex_mem_mem_read, ex_mem_mem_write;
    logic [31:0] ex_mem_addr, ex_mem_store_data;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_reg_wen, ex_mem_halt, stall_in, dhit;
    logic [31:0] dmemload;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore, wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_wen, wb_halt, mem_wb_en, mem_wb_flush, mem_stall, halted, mem_err;

    int checks   = 0;
    int failures = 0;

    mem_stage_ctrl #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .ex_mem_valid(ex_mem_valid), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_addr(ex_mem_addr),
        .ex_mem_store_data(ex_mem_store_data), .ex_mem_rd(ex_mem_rd),
        .ex_mem_reg_wen(ex_mem_reg_wen), .ex_mem_halt(ex_mem_halt),
        .stall_in(stall_in), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_wen(wb_reg_wen), .wb_halt(wb_halt), .mem_wb_en(mem_wb_en),
        .mem_wb_flush(mem_wb_flush), .mem_stall(mem_stall),
        .halted(halted), .mem_err(mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        v, r, w;
        logic [31:0] addr, sd;
        logic [4:0]  rd;
        logic        rwen, stall, dh;
        logic [31:0] load;
        logic        eren, ewen;
        logic [31:0] edaddr, edst, ewb;
        logic        een, efl, est;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic r, input logic w,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input logic rwen, input logic halt,
                         input logic stall, input logic dh, input logic [31:0] load);
        ex_mem_valid      = v;
        ex_mem_mem_read   = r;
        ex_mem_mem_write  = w;
        ex_mem_addr       = addr;
        ex_mem_store_data = sd;
        ex_mem_rd         = rd;
        ex_mem_reg_wen    = rwen;
        ex_mem_halt       = halt;
        stall_in          = stall;
        dhit              = dh;
        dmemload          = load;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        // Every vector leaves the FSM in IDLE so they can be applied back to back.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h10,  32'hAAAA,     5'd5, 1'b1, 1'b0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0,   32'h0,        32'h10,       1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'h77,       5'd6, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF,
                    1'b1, 1'b0, 32'h100, 32'h77,       32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h104, 32'h12345678, 5'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF,
                    1'b0, 1'b1, 32'h104, 32'h12345678, 32'h104,      1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h108, 32'h9,        5'd7, 1'b1, 1'b0, 1'b1, 32'h4242,
                    1'b1, 1'b0, 32'h108, 32'h9,        32'h4242,     1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h24,  32'h1,        5'd0, 1'b0, 1'b0, 1'b0, 32'hBAD,
                    1'b0, 1'b0, 32'h0,   32'h0,        32'hBAD,      1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h30,  32'h0,        5'd3, 1'b1, 1'b1, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0,   32'h0,        32'h30,       1'b0, 1'b0, 1'b0};

        // Reset: all outputs low even with a hitting load presented.
        nRST = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h50, 32'h5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1111);
        #1 nRST = 1'b0;
        #2;
        chk("rst_ren",    {31'd0, dmemREN},   32'd0);
        chk("rst_wben",   {31'd0, mem_wb_en}, 32'd0);
        chk("rst_stall",  {31'd0, mem_stall}, 32'd0);
        chk("rst_addr",   dmemaddr,           32'd0);
        chk("rst_wbdata", wb_data,            32'd0);
        chk("rst_halted", {31'd0, halted},    32'd0);
        chk("rst_err",    {31'd0, mem_err},   32'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        drive_idle();
        nRST = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            drive(vecs[i].v, vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].sd, vecs[i].rd,
                  vecs[i].rwen, 1'b0, vecs[i].stall, vecs[i].dh, vecs[i].load);
            #2;
            chk($sformatf("vec%0d_ren", i),   {31'd0, dmemREN},      {31'd0, vecs[i].eren});
            chk($sformatf("vec%0d_wen", i),   {31'd0, dmemWEN},      {31'd0, vecs[i].ewen});
            chk($sformatf("vec%0d_daddr", i), dmemaddr,              vecs[i].edaddr);
            chk($sformatf("vec%0d_dstore", i), dmemstore,            vecs[i].edst);
            chk($sformatf("vec%0d_wbdata", i), wb_data,              vecs[i].ewb);
            chk($sformatf("vec%0d_en", i),    {31'd0, mem_wb_en},    {31'd0, vecs[i].een});
            chk($sformatf("vec%0d_flush", i), {31'd0, mem_wb_flush}, {31'd0, vecs[i].efl});
            chk($sformatf("vec%0d_stall", i), {31'd0, mem_stall},    {31'd0, vecs[i].est});
            chk($sformatf("vec%0d_wbrd", i),  {27'd0, wb_rd},        {27'd0, vecs[i].rd});
            chk($sformatf("vec%0d_wbwen", i), {31'd0, wb_reg_wen},   {31'd0, vecs[i].rwen});
        end

        // Store, dhit arrives on the 4th cycle.
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            drive(1'b1, 1'b0, 1'b1, 32'h200, 32'hCAFE, 5'd0, 1'b0, 1'b0, 1'b0, (c == 4), 32'h0);
            #2;
            chk($sformatf("st_c%0d_wen", c),   {31'd0, dmemWEN},   32'd1);
            chk($sformatf("st_c%0d_stall", c), {31'd0, mem_stall}, (c < 4) ? 32'd1 : 32'd0);
            chk($sformatf("st_c%0d_en", c),    {31'd0, mem_wb_en}, (c == 4) ? 32'd1 : 32'd0);
        end
        chk("st_dstore", dmemstore, 32'hCAFE);
        @(negedge CLK);
        drive_idle();
        #2 chk("st_err_clear", {31'd0, mem_err}, 32'd0);

        // Load completes while frozen, then drains from the hold register.
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234);
        #2;
        chk("hold_c0_ren", {31'd0, dmemREN},   32'd1);
        chk("hold_c0_en",  {31'd0, mem_wb_en}, 32'd0);
        for (int c = 1; c <= 2; c++) begin
            @(negedge CLK);
            dhit = 1'b0;
            dmemload = 32'h0;
            #2;
            chk($sformatf("hold_c%0d_ren", c),   {31'd0, dmemREN},   32'd0);
            chk($sformatf("hold_c%0d_en", c),    {31'd0, mem_wb_en}, 32'd0);
            chk($sformatf("hold_c%0d_stall", c), {31'd0, mem_stall}, 32'd0);
        end
        @(negedge CLK);
        stall_in = 1'b0;
        #2;
        chk("hold_rel_en",     {31'd0, mem_wb_en}, 32'd1);
        chk("hold_rel_wbdata", wb_data,            32'h1234);
        chk("hold_rel_ren",    {31'd0, dmemREN},   32'd0);
        @(negedge CLK);
        drive_idle();

        // Timeout: four miss cycles set mem_err (visible from the 5th cycle on).
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge CLK);
            #2;
            chk($sformatf("to_c%0d_ren", k), {31'd0, dmemREN}, 32'd1);
            chk($sformatf("to_c%0d_err", k), {31'd0, mem_err}, (k >= 5) ? 32'd1 : 32'd0);
        end
        @(negedge CLK);
        dhit = 1'b1;
        dmemload = 32'h55AA;
        #2;
        chk("to_done_en",     {31'd0, mem_wb_en}, 32'd1);
        chk("to_done_wbdata", wb_data,            32'h55AA);
        chk("to_done_stall",  {31'd0, mem_stall}, 32'd0);
        @(negedge CLK);
        drive_idle();
        #2 chk("to_err_sticky", {31'd0, mem_err}, 32'd1);

        // Halt retires, then later memops are bubbled out.
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        #2;
        chk("halt_en",      {31'd0, mem_wb_en}, 32'd1);
        chk("halt_wbhalt",  {31'd0, wb_halt},   32'd1);
        chk("halt_pre",     {31'd0, halted},    32'd0);
        @(negedge CLK);
        drive(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h99);
        #2;
        chk("halted_set",   {31'd0, halted},       32'd1);
        chk("halted_ren",   {31'd0, dmemREN},      32'd0);
        chk("halted_en",    {31'd0, mem_wb_en},    32'd0);
        chk("halted_flush", {31'd0, mem_wb_flush}, 32'd0);
        #1 nRST = 1'b0;
        #1;
        chk("arst_halted", {31'd0, halted},  32'd0);
        chk("arst_err",    {31'd0, mem_err}, 32'd0);
        chk("arst_ren",    {31'd0, dmemREN}, 32'd0);

        // Reset mid-ACCESS must land in IDLE, not resume the access.
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge CLK);
        #2;
        chk("acc_ren",   {31'd0, dmemREN},   32'd1);
        chk("acc_stall", {31'd0, mem_stall}, 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk("acc_arst_ren",   {31'd0, dmemREN},   32'd0);
        chk("acc_arst_addr",  dmemaddr,           32'd0);
        chk("acc_arst_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h600, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        chk("post_rst_ren",   {31'd0, dmemREN},      32'd0);
        chk("post_rst_en",    {31'd0, mem_wb_en},    32'd1);
        chk("post_rst_flush", {31'd0, mem_wb_flush}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
